multiplexor_display: RTL and testbench

Four-digit time-multiplexed scan controller for the Nexys 3 seven-segment display. It is the producer side of the 4-bit digit code consumed by the registered segment decoder (Memoria_display).
- Cycles through the four digits and presents one 4-bit code per digit period.
- Drives the active-low anodes, with a blanking guard interval so the decoder's 1-cycle registered latency never shows a ghost segment pattern.
- Snapshots its 16-bit input once per frame, so the displayed value never tears.
- Optionally blanks leading zeros.

---
 rtl/multiplexor_display_pkg.sv | 27 ++
 rtl/divisor_refresco.sv | 35 +++
 rtl/multiplexor_display.sv | 101 ++++++++++
 tb/tb_multiplexor_display.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/multiplexor_display_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan controller.
// Digit codes are 4 bits; 4'hF is the blank code understood by the segment decoder.
package multiplexor_display_pkg;

    localparam int unsigned NUM_DIGITOS     = 4;
    localparam logic [3:0]  ANODOS_APAGADOS = 4'b1111;
    localparam logic [3:0]  CODIGO_BLANCO   = 4'hF;

    function automatic bit parametros_validos(input int unsigned refresh_div,
                                              input int unsigned guard_cycles);
        return (guard_cycles >= 1) && (refresh_div > guard_cycles + 1);
    endfunction

    // Digit idx is blanked when leading-zero suppression is on and it and all higher
    // digits are zero; digit 0 always shows.
    function automatic logic [3:0] codigo_digito(input logic [15:0] snap,
                                                 input logic        blank,
                                                 input logic [1:0]  idx);
        logic [15:0] resto;
        resto = snap >> {idx, 2'b00};
        if (blank && (idx != 2'd0) && (resto == 16'h0000)) begin
            return CODIGO_BLANCO;
        end
        return resto[3:0];
    endfunction

endpackage

// File: rtl/divisor_refresco.sv
// Digit-period prescaler: counts 0..REFRESH_DIV-1 and flags the last count so the
// following edge is the wrap edge.
module divisor_refresco #(
    parameter int unsigned REFRESH_DIV = 25000,
    parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             CLK,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == ULTIMO) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = (cnt_q == ULTIMO);

endmodule

// File: rtl/multiplexor_display.sv
// Four-digit time-multiplexed scan controller: per-frame input snapshot, leading-zero
// blanking and guarded active-low anode drive for a registered segment decoder.
module multiplexor_display
    import multiplexor_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 25000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] digitos,
    input  logic        blank_ceros,
    output logic [3:0]  numero,
    output logic [3:0]  anodos,
    output logic        tick_trama
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    if (!parametros_validos(REFRESH_DIV, GUARD_CYCLES)) begin : g_param_error
        $error("multiplexor_display: need GUARD_CYCLES >= 1 and REFRESH_DIV > GUARD_CYCLES+1");
    end

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    divisor_refresco #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_divisor_refresco (
        .CLK   (CLK),
        .reset (reset),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    logic [1:0]  idx_q, idx_d;
    logic [15:0] snapshot_q, snapshot_d;
    logic        snap_blank_q, snap_blank_d;
    logic        load_pending_q, load_pending_d;
    logic [3:0]  anodos_q, anodos_d;
    logic [3:0]  numero_q, numero_d;
    logic        tick_q, tick_d;
    logic        frame_start;

    always_comb begin
        idx_d          = idx_q;
        snapshot_d     = snapshot_q;
        snap_blank_d   = snap_blank_q;
        load_pending_d = load_pending_q;
        anodos_d       = anodos_q;
        numero_d       = numero_q;
        tick_d         = 1'b0;

        frame_start = load_pending_q || (wrap && (idx_q == 2'd3));

        if (wrap) begin
            idx_d = idx_q + 2'd1;
        end

        if (frame_start) begin
            snapshot_d     = digitos;
            snap_blank_d   = blank_ceros;
            load_pending_d = 1'b0;
            tick_d         = 1'b1;
        end

        // Code comes from the next-state snapshot so digit 0 of a new frame is fresh.
        if (wrap || frame_start) begin
            anodos_d = ANODOS_APAGADOS;
            numero_d = codigo_digito(snapshot_d, snap_blank_d, idx_d);
        end else if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
            anodos_d = ~(4'b0001 << idx_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            idx_q          <= 2'd0;
            snapshot_q     <= 16'h0000;
            snap_blank_q   <= 1'b0;
            load_pending_q <= 1'b1;
            anodos_q       <= ANODOS_APAGADOS;
            numero_q       <= CODIGO_BLANCO;
            tick_q         <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            snapshot_q     <= snapshot_d;
            snap_blank_q   <= snap_blank_d;
            load_pending_q <= load_pending_d;
            anodos_q       <= anodos_d;
            numero_q       <= numero_d;
            tick_q         <= tick_d;
        end
    end

    assign numero     = numero_q;
    assign anodos     = anodos_q;
    assign tick_trama = tick_q;

endmodule

// File: tb/tb_multiplexor_display.sv
// Directed bench for multiplexor_display with REFRESH_DIV=8, GUARD_CYCLES=2; a one-cycle
// register stands in for the segment decoder to check display alignment.
module tb_multiplexor_display;

    localparam int unsigned REFRESH_DIV  = 8;
    localparam int unsigned GUARD_CYCLES = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] digitos;
    logic        blank_ceros;
    logic [3:0]  numero;
    logic [3:0]  anodos;
    logic        tick_trama;
    logic [3:0]  seg_code;

    int n_vec  = 0;
    int n_miss = 0;

    multiplexor_display #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .digitos     (digitos),
        .blank_ceros (blank_ceros),
        .numero      (numero),
        .anodos      (anodos),
        .tick_trama  (tick_trama)
    );

    always #5 CLK = ~CLK;

    // Decoder stand-in: what the segment bus encodes one cycle after numero.
    always @(posedge CLK) seg_code <= numero;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // shown holds the expected displayed code per digit, digit 0 in [3:0]; k is the cycle
    // index within the frame (k=0 is the sample right after the frame-start edge).
    task automatic run_digits(input logic [15:0] shown, input int first_k, input int last_k);
        for (int k = first_k; k <= last_k; k++) begin
            int         d;
            int         c;
            int         on_d;
            logic [3:0] exp_an;
            step();
            d      = k / REFRESH_DIV;
            c      = k % REFRESH_DIV;
            exp_an = (c < GUARD_CYCLES) ? 4'b1111 : ~(4'b0001 << d);
            check($sformatf("numero k=%0d", k), {12'h0, numero}, {12'h0, shown[4*d +: 4]});
            check($sformatf("anodos k=%0d", k), {12'h0, anodos}, {12'h0, exp_an});
            check($sformatf("tick k=%0d", k), {15'h0, tick_trama}, {15'h0, (k == 0)});
            if (anodos != 4'b1111) begin
                case (anodos)
                    4'b1110: on_d = 0;
                    4'b1101: on_d = 1;
                    4'b1011: on_d = 2;
                    4'b0111: on_d = 3;
                    default: on_d = d;
                endcase
                check($sformatf("seg k=%0d", k), {12'h0, seg_code}, {12'h0, shown[4*on_d +: 4]});
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        digitos     = 16'h1234;
        blank_ceros = 1'b0;

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst anodos", {12'h0, anodos}, 16'h000F);
            check("rst numero", {12'h0, numero}, 16'h000F);
            check("rst tick", {15'h0, tick_trama}, 16'h0000);
        end

        // First edge after release starts a frame; counter is already at 1
        reset = 1'b0;
        step();
        check("start tick", {15'h0, tick_trama}, 16'h0001);
        check("start numero", {12'h0, numero}, 16'h0004);
        check("start anodos", {12'h0, anodos}, 16'h000F);
        run_digits(16'h1234, 2, 31);
        run_digits(16'h1234, 0, 31);

        // Leading-zero suppression and non-BCD pass-through
        digitos = 16'h0070; blank_ceros = 1'b1;
        run_digits(16'hFF70, 0, 31);
        blank_ceros = 1'b0;
        run_digits(16'h0070, 0, 31);
        digitos = 16'h0000; blank_ceros = 1'b1;
        run_digits(16'hFFF0, 0, 31);
        digitos = 16'hA0B0;
        run_digits(16'hA0B0, 0, 31);

        // Input change mid-frame waits for the next frame
        digitos = 16'h1234; blank_ceros = 1'b0;
        run_digits(16'h1234, 0, 19);
        digitos = 16'h5678; blank_ceros = 1'b1;
        run_digits(16'h1234, 20, 31);
        blank_ceros = 1'b0;
        run_digits(16'h5678, 0, 31);

        // One-cycle reset at idx=2, cnt=5
        run_digits(16'h5678, 0, 21);
        reset   = 1'b1;
        digitos = 16'h4321;
        step();
        check("midrst anodos", {12'h0, anodos}, 16'h000F);
        check("midrst numero", {12'h0, numero}, 16'h000F);
        check("midrst tick", {15'h0, tick_trama}, 16'h0000);
        reset = 1'b0;
        step();
        check("restart tick", {15'h0, tick_trama}, 16'h0001);
        check("restart numero", {12'h0, numero}, 16'h0001);
        check("restart anodos", {12'h0, anodos}, 16'h000F);
        step();
        check("restart anode0", {12'h0, anodos}, 16'h000E);
        check("restart numero2", {12'h0, numero}, 16'h0001);
        run_digits(16'h4321, 3, 31);
        run_digits(16'h4321, 0, 31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
